// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and counter width helper for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or after ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);
  logic [W-1:0] idx;
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) winner = idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that funnels requester beats into one FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FIFO_WIDTH   = 16,
  parameter int BURST_MAX    = 4,
  parameter int HOLD_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_pulse
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = cnt_w(BURST_MAX);
  localparam int TW = cnt_w(HOLD_TIMEOUT);
  localparam bit POW2 = (NUM_REQ & (NUM_REQ - 1)) == 0;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, winner, ptr_nxt;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] idle_cnt;
  logic any, owner_valid, in_grant, burst_end, tmo;
  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .winner(winner),
    .any(any)
  );
  // Outputs are gated by rst so a beat presented in the reset cycle is never written.
  always_comb begin
    owner_valid = req_valid[grant_id];
    in_grant = state == GRANT && !rst;
    busy = in_grant;
    req_ready = (in_grant && !fifo_full) ? NUM_REQ'(1) << grant_id : '0;
    fifo_wr_en = in_grant && !fifo_full && owner_valid;
    fifo_data_in = req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
    burst_end = fifo_wr_en && (req_last[grant_id] || beat_cnt == BW'(BURST_MAX - 1));
    tmo = in_grant && !owner_valid && idle_cnt == TW'(HOLD_TIMEOUT - 1);
    ptr_nxt = (POW2 || grant_id != IW'(NUM_REQ - 1)) ? grant_id + 1'b1 : '0;
    state_n = (state == IDLE) ? (any ? GRANT : IDLE) : ((burst_end || tmo) ? IDLE : GRANT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state <= state_n;
      timeout_pulse <= tmo;
      if (state == IDLE) begin
        beat_cnt <= '0;
        idle_cnt <= '0;
        if (any) grant_id <= winner;
      end else begin
        if (fifo_wr_en) beat_cnt <= beat_cnt + 1'b1;
        idle_cnt <= owner_valid ? '0 : idle_cnt + 1'b1;
        if (burst_end || tmo) rr_ptr <= ptr_nxt;
      end
    end
  end
endmodule
